// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-cache line-fill requester and a
// data-cache fill/write-back requester. One transaction at a time, round-robin on ties, and a
// one-cycle recovery gap after every completion so the requester can drop its request.
module mem_arbiter #(
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,

  // Instruction cache side
  input  logic                  i_read,
  input  logic [31:0]           i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,

  // Data cache side
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [31:0]           d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,

  // Shared memory port
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {
    StIdle,
    StServeI,
    StServeD,
    StRecover
  } state_e;

  // Which side received the most recent grant; the other side wins the next tie.
  typedef enum logic {
    GrantI,
    GrantD
  } grant_e;

  state_e                  state_q, state_d;
  grant_e                  last_grant_q, last_grant_d;
  logic [31:0]             addr_q, addr_d;
  logic                    op_write_q, op_write_d;
  logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;

  logic i_pend;
  logic d_pend;
  logic serving;

  assign i_pend  = i_read;
  assign d_pend  = d_read | d_write;
  assign serving = (state_q == StServeI) || (state_q == StServeD);

  // State and latched-transaction registers; synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= GrantI;
      addr_q       <= '0;
      op_write_q   <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      op_write_q   <= op_write_d;
      wdata_q      <= wdata_d;
    end
  end

  // Next-state logic: arbitrate in idle, wait for mem_resp while serving, then one recovery cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    op_write_d   = op_write_q;
    wdata_d      = wdata_q;

    case (state_q)
      StIdle: begin
        // D wins when it is alone, or on a tie when I was granted last.
        if (d_pend && (!i_pend || (last_grant_q == GrantI))) begin
          state_d      = StServeD;
          last_grant_d = GrantD;
          addr_d       = d_address;
          // A simultaneous read and write is treated as a write-back.
          op_write_d   = d_write;
          wdata_d      = d_wdata;
        end else if (i_pend) begin
          state_d      = StServeI;
          last_grant_d = GrantI;
          addr_d       = i_address;
          op_write_d   = 1'b0;
          wdata_d      = d_wdata;
        end
      end
      StServeI, StServeD: begin
        // Completion is only tracked here; dropped requests do not abort a transaction.
        if (mem_resp) begin
          state_d = StRecover;
        end
      end
      StRecover: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Memory-port drive comes purely from registers, so requester inputs never reach it directly.
  always_comb begin
    mem_read    = serving && !op_write_q;
    mem_write   = serving && op_write_q;
    mem_address = addr_q;
    mem_wdata   = wdata_q;
  end

  // Completion pulses and returned lines; mem_resp outside a serving state is ignored.
  always_comb begin
    i_resp  = (state_q == StServeI) && mem_resp;
    d_resp  = (state_q == StServeD) && mem_resp;
    i_rdata = i_resp ? mem_rdata : '0;
    d_rdata = d_resp ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized request rounds, checked against a
// transaction-level model (pending sets, round-robin "other side wins a tie", one op per grant).
module tb_mem_arbiter;

  localparam int unsigned LW = 256;

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [31:0]   i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [31:0]   d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  int n_checks;
  int n_err;
  bit last_d;  // model: 1 when the data side received the most recent grant

  mem_arbiter #(.LINE_WIDTH(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < int'(LW / 32); k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[4:0] = 5'd0;
    return a;
  endfunction

  // Called in an idle cycle with the request(s) already driven. Expects the grant on the next
  // edge, holds it for lat cycles, responds, checks the completion and the recovery gap, and
  // returns in the following idle cycle.
  task automatic serve_one(input bit side, input logic [31:0] addr, input bit wr,
                           input logic [LW-1:0] wd, input int lat, input bit drop_early);
    logic [LW-1:0] rd;
    int waited;
    tick();
    chk("grant_latency", (mem_read | mem_write), 1);
    waited = 0;
    while (!(mem_read | mem_write) && waited < 20) begin
      tick();
      waited++;
    end
    if (!(mem_read | mem_write)) begin
      chk("grant_timeout", (mem_read | mem_write), 1);
      return;
    end
    for (int c = 0; c < lat; c++) begin
      mem_rdata = rand_line();
      #1;
      chk("serve_mem_read", mem_read, !wr);
      chk("serve_mem_write", mem_write, wr);
      chk("serve_mem_address", mem_address, addr);
      if (wr) chk("serve_mem_wdata", mem_wdata, wd);
      chk("serve_no_i_resp", i_resp, 0);
      chk("serve_no_d_resp", d_resp, 0);
      chk("serve_i_rdata_zero", i_rdata, '0);
      chk("serve_d_rdata_zero", d_rdata, '0);
      if (drop_early && c == 0) begin
        if (side) begin
          d_read  = 1'b0;
          d_write = 1'b0;
        end else begin
          i_read = 1'b0;
        end
      end
      tick();
    end
    rd = rand_line();
    mem_rdata = rd;
    mem_resp  = 1'b1;
    #1;
    chk("resp_mem_address", mem_address, addr);
    chk("resp_i_resp", i_resp, !side);
    chk("resp_d_resp", d_resp, side);
    chk("resp_i_rdata", i_rdata, side ? '0 : rd);
    chk("resp_d_rdata", d_rdata, side ? rd : '0);
    tick();
    mem_resp = 1'b0;
    if (side) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    // Recovery cycle: no request on the port, stray mem_resp produces nothing.
    mem_resp = 1'($urandom_range(0, 1));
    #1;
    chk("recover_mem_read", mem_read, 0);
    chk("recover_mem_write", mem_write, 0);
    chk("recover_i_resp", i_resp, 0);
    chk("recover_d_resp", d_resp, 0);
    mem_resp = 1'b0;
    tick();
    chk("idle_mem_read", mem_read, 0);
    chk("idle_mem_write", mem_write, 0);
    last_d = side;
  endtask

  // Drain every pending request, choosing the winner from the model's round-robin rule.
  task automatic run_pending();
    bit win;
    bit ip;
    bit dp;
    ip = i_read;
    dp = d_read | d_write;
    while (ip || dp) begin
      win = (ip && dp) ? !last_d : dp;
      serve_one(win, win ? d_address : i_address, win & d_write, d_wdata,
                $urandom_range(1, 6), 1'($urandom_range(0, 3) == 0));
      ip = i_read;
      dp = d_read | d_write;
    end
  endtask

  initial begin
    logic [LW-1:0] a5_line;
    logic [LW-1:0] pat;
    int sel;
    int dop;

    n_checks  = 0;
    n_err     = 0;
    last_d    = 1'b0;
    rst       = 1'b1;
    i_read    = 1'b0;
    i_address = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_address = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_resp  = 1'b0;

    // Reset state
    tick();
    tick();
    chk("reset_mem_read", mem_read, 0);
    chk("reset_mem_write", mem_write, 0);
    chk("reset_mem_address", mem_address, 0);
    chk("reset_mem_wdata", mem_wdata, '0);
    chk("reset_i_resp", i_resp, 0);
    chk("reset_d_resp", d_resp, 0);
    rst = 1'b0;
    tick();

    // Tie right after reset: D first, then I after recovery
    i_read    = 1'b1;
    i_address = 32'h0000_0100;
    d_read    = 1'b1;
    d_address = 32'h0000_0200;
    serve_one(1'b1, 32'h0000_0200, 1'b0, '0, 3, 1'b0);
    serve_one(1'b0, 32'h0000_0100, 1'b0, '0, 2, 1'b0);

    // Continuous contention: grants alternate D, I, D, I
    i_read    = 1'b1;
    i_address = rand_addr();
    d_read    = 1'b1;
    d_address = rand_addr();
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        serve_one(1'b1, d_address, 1'b0, '0, 2, 1'b0);
        d_read    = 1'b1;
        d_address = rand_addr();
      end else begin
        serve_one(1'b0, i_address, 1'b0, '0, 2, 1'b0);
        if (k != 3) begin
          i_read    = 1'b1;
          i_address = rand_addr();
        end
      end
    end
    run_pending();

    // Lone instruction fill with a five-cycle memory latency
    for (int k = 0; k < int'(LW / 8); k++) a5_line[k*8 +: 8] = 8'hA5;
    i_read    = 1'b1;
    i_address = 32'h0000_1000;
    tick();
    chk("lone_i_mem_read", mem_read, 1);
    chk("lone_i_mem_address", mem_address, 32'h0000_1000);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("lone_i_hold", mem_read, 1);
    end
    mem_rdata = a5_line;
    mem_resp  = 1'b1;
    #1;
    chk("lone_i_resp", i_resp, 1);
    chk("lone_i_rdata", i_rdata, a5_line);
    chk("lone_i_no_d_resp", d_resp, 0);
    tick();
    mem_resp = 1'b0;
    i_read   = 1'b0;
    #1;
    chk("lone_i_recover_resp", i_resp, 0);
    chk("lone_i_recover_read", mem_read, 0);
    tick();
    last_d = 1'b0;

    // Write-back with stable address/data until completion
    for (int k = 0; k < int'(LW / 16); k++) pat[k*16 +: 16] = 16'h1234 + 16'(k);
    d_write   = 1'b1;
    d_address = 32'h0000_8040;
    d_wdata   = pat;
    serve_one(1'b1, 32'h0000_8040, 1'b1, pat, 4, 1'b0);

    // Read and write together are a write; stray mem_resp in idle is ignored
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 32'h0000_0040;
    d_wdata   = rand_line();
    serve_one(1'b1, 32'h0000_0040, 1'b1, d_wdata, 2, 1'b0);
    mem_resp = 1'b1;
    #1;
    chk("stray_idle_i_resp", i_resp, 0);
    chk("stray_idle_d_resp", d_resp, 0);
    tick();
    mem_resp = 1'b0;
    tick();

    // Reset two cycles into a data write-back abandons it
    d_write   = 1'b1;
    d_address = 32'h0000_0080;
    d_wdata   = rand_line();
    tick();
    chk("abort_mem_write", mem_write, 1);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_after_rst_write", mem_write, 0);
    chk("abort_after_rst_read", mem_read, 0);
    chk("abort_after_rst_address", mem_address, 0);
    chk("abort_after_rst_wdata", mem_wdata, '0);
    d_write  = 1'b0;
    rst      = 1'b0;
    mem_resp = 1'b1;
    #1;
    chk("abort_stray_d_resp", d_resp, 0);
    chk("abort_stray_i_resp", i_resp, 0);
    tick();
    mem_resp = 1'b0;
    last_d   = 1'b0;
    i_read    = 1'b1;
    i_address = 32'h0000_0300;
    run_pending();

    // Randomized rounds
    for (int r = 0; r < 30; r++) begin
      sel = $urandom_range(1, 3);
      dop = $urandom_range(0, 2);
      i_read    = sel[0];
      i_address = rand_addr();
      d_read    = sel[1] && (dop != 1);
      d_write   = sel[1] && (dop != 0);
      d_address = rand_addr();
      d_wdata   = rand_line();
      run_pending();
      if ($urandom_range(0, 3) == 0) begin
        mem_resp = 1'b1;
        #1;
        chk("rand_stray_i_resp", i_resp, 0);
        chk("rand_stray_d_resp", d_resp, 0);
        tick();
        mem_resp = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LINE_WIDTH, 256, width in bits of one cache line on every data bus.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 i_read  input  1  instruction-cache line-fill request; held high until i_resp.
REQ-005 i_address  input  32  instruction line address, bits [4:0] zero.
REQ-006 i_rdata  output  LINE_WIDTH  line returned to instruction cache.
REQ-007 i_resp  output  1  one-cycle completion pulse to instruction cache.
REQ-008 d_read  input  1  data-cache line-fill request; held high until d_resp.
REQ-009 d_write  input  1  data-cache write-back request; held high until d_resp.
REQ-010 d_address  input  32  data line address, bits [4:0] zero.
REQ-011 d_wdata  input  LINE_WIDTH  write-back line from data cache.
REQ-012 d_rdata  output  LINE_WIDTH  line returned to data cache.
REQ-013 d_resp  output  1  one-cycle completion pulse to data cache.
REQ-014 mem_read  output  1  read request to shared memory port.
REQ-015 mem_write  output  1  write request to shared memory port.
REQ-016 mem_address  output  32  address to shared memory port.
REQ-017 mem_wdata  output  LINE_WIDTH  write data to shared memory port.
REQ-018 mem_rdata  input  LINE_WIDTH  read data from shared memory port, valid with mem_resp.
REQ-019 mem_resp  input  1  one-cycle completion pulse from shared memory port.

Function
REQ-020 FSM states: IDLE, SERVE_I, SERVE_D, RECOVER; state, grant address, op and wdata registered.
REQ-021 IDLE: no request -> stay IDLE; only i_read -> SERVE_I; only d_read or d_write -> SERVE_D.
REQ-022 IDLE with I and D pending: grant side NOT held in last_grant register (round robin); last_grant resets to I, so D wins first tie after reset.
REQ-023 On transition to SERVE_x: latch address, op (read/write) and d_wdata; update last_grant to x.
REQ-024 d_read and d_write both high: treated as write; d_read ignored for that grant.
REQ-025 SERVE_x: mem_read/mem_write asserted from latched op, mem_address/mem_wdata from latched registers, constant until mem_resp.
REQ-026 Latency: request high in IDLE at edge N -> memory request visible in cycle after edge N; no combinational path from i_*/d_* request inputs to mem_* outputs.
REQ-027 SERVE_x with mem_resp: x_resp=1 same cycle (combinational), x_rdata=mem_rdata same cycle; next state RECOVER.
REQ-028 RECOVER: one cycle, mem_read=mem_write=0, no grant, allows requester to drop request; then IDLE.
REQ-029 Non-granted side: resp=0 at all times; rdata outputs drive mem_rdata only qualified by its own resp (value otherwise don't-care, drive 0).
REQ-030 Requester dropping request mid-service: transaction still completes to mem_resp; resp pulse still issued.
REQ-031 mem_resp while IDLE or RECOVER: ignored, no resp to either side.
REQ-032 Never mem_read and mem_write both high; never i_resp and d_resp both high.

Reset
REQ-033 rst high at edge: state=IDLE, last_grant=I, latched address/wdata=0, op=read.
REQ-034 During and after reset: mem_read=mem_write=0, i_resp=d_resp=0, mem_address=0, mem_wdata=0.
REQ-035 Reset mid-SERVE_x: outstanding transaction abandoned, no resp issued; a later stray mem_resp ignored per REQ-031.

Verification
REQ-036 Lone i_read, i_address=0x0000_1000; mem_resp after 5 cycles with mem_rdata=0xA5..A5 -> mem_read one cycle after request, i_resp one pulse with i_rdata=0xA5..A5, RECOVER then IDLE.
REQ-037 i_read and d_read both high after reset (0x100, 0x200) -> D served first (mem_address=0x200), then I (0x100); second request issued after RECOVER.
REQ-038 Back-to-back contention, D always pending, I pending -> grants alternate D,I,D,I; I never starved more than one transaction.
REQ-039 d_write, d_address=0x0000_8040, d_wdata=0x1234..; mem_address/mem_wdata stable every cycle until mem_resp; d_resp pulse; mem_read stays 0.
REQ-040 rst asserted 2 cycles into SERVE_D, then mem_resp pulses -> no d_resp, mem_write=0 after reset edge, state IDLE.
REQ-041 d_read and d_write both high, d_address=0x40 -> mem_write=1, mem_read=0; stray mem_resp in IDLE produces no resp.
